// File: rtl/nes_bus_pkg.sv
// Shared NES CPU-bus definitions: M2 phase encoding, address map and default
// cycle timing used by the bus master and related cartridge-side blocks.
package nes_bus_pkg;

    typedef enum logic {
        PH_LOW  = 1'b0,
        PH_HIGH = 1'b1
    } phase_e;

    localparam logic [15:0] SRAM_BASE = 16'h6000;
    localparam logic [15:0] ROM_BASE  = 16'h8000;

    localparam int          DEF_M2_LOW_CYCLES  = 5;
    localparam int          DEF_M2_HIGH_CYCLES = 7;
    localparam logic [15:0] DEF_IDLE_ADDR      = 16'h0000;

    // One latched bus cycle; host=0 marks an idle filler read.
    typedef struct packed {
        logic        host;
        logic        write;
        logic [15:0] addr;
    } bus_cyc_t;

    function automatic logic in_rom(input logic [15:0] a);
        return a >= ROM_BASE;
    endfunction

endpackage

// File: rtl/nes_bus_sync2.sv
// Two-flop synchronizer for asynchronous cartridge-side signals (IRQ etc.).
module nes_bus_sync2 #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/nes_cpu_bus_master.sv
// NES CPU-bus initiator: free-running M2 with idle reads, host-issued single
// reads/writes slotted into bus cycles, and an IRQ synchronizer.
module nes_cpu_bus_master
    import nes_bus_pkg::*;
#(
    parameter int          M2_LOW_CYCLES  = DEF_M2_LOW_CYCLES,
    parameter int          M2_HIGH_CYCLES = DEF_M2_HIGH_CYCLES,
    parameter logic [15:0] IDLE_ADDR      = DEF_IDLE_ADDR
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [15:0] req_addr,
    input  logic [7:0]  req_wdata,
    output logic        resp_valid,
    output logic [7:0]  resp_rdata,
    output logic        m2,
    output logic        romsel,
    output logic        cpu_rw,
    output logic [14:0] cpu_addr,
    output logic [7:0]  cpu_data_out,
    output logic        cpu_data_oe,
    input  logic [7:0]  cpu_data_in,
    input  logic        irq,
    output logic        irq_sync
);

    localparam int MAX_CYC = (M2_LOW_CYCLES > M2_HIGH_CYCLES) ? M2_LOW_CYCLES : M2_HIGH_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CYC);
    localparam logic [CNT_W-1:0] LOW_LAST  = CNT_W'(M2_LOW_CYCLES - 1);
    localparam logic [CNT_W-1:0] HIGH_LAST = CNT_W'(M2_HIGH_CYCLES - 1);

    phase_e           phase, phase_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             run;
    bus_cyc_t         cyc, cyc_nxt;
    logic             hi_last, cyc_start, accept;
    logic             oe_q, oe_nxt;
    logic [7:0]       data_out_q;

    // run is clear only during reset; the first edge after release opens
    // the first LOW phase so address setup is honoured from the start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase <= PH_LOW;
            cnt   <= '0;
            run   <= 1'b0;
        end else begin
            phase <= phase_nxt;
            cnt   <= cnt_nxt;
            run   <= 1'b1;
        end
    end

    always_comb begin
        phase_nxt = phase;
        cnt_nxt   = cnt + 1'b1;
        hi_last   = 1'b0;
        if (!run) begin
            phase_nxt = PH_LOW;
            cnt_nxt   = '0;
        end else begin
            case (phase)
                PH_LOW: begin
                    if (cnt == LOW_LAST) begin
                        phase_nxt = PH_HIGH;
                        cnt_nxt   = '0;
                    end
                end
                PH_HIGH: begin
                    if (cnt == HIGH_LAST) begin
                        phase_nxt = PH_LOW;
                        cnt_nxt   = '0;
                        hi_last   = 1'b1;
                    end
                end
                default: begin
                    phase_nxt = PH_LOW;
                    cnt_nxt   = '0;
                end
            endcase
        end
    end

    assign cyc_start = !run || hi_last;
    assign req_ready = hi_last;
    assign accept    = req_valid && req_ready;

    always_comb begin
        cyc_nxt = cyc;
        if (cyc_start) begin
            if (accept) begin
                cyc_nxt.host  = 1'b1;
                cyc_nxt.write = req_write;
                cyc_nxt.addr  = req_addr;
            end else begin
                cyc_nxt.host  = 1'b0;
                cyc_nxt.write = 1'b0;
                cyc_nxt.addr  = IDLE_ADDR;
            end
        end
    end

    // Driver on for all of HIGH plus the first clk after M2 falls (hold).
    assign oe_nxt = cyc.write && (phase_nxt == PH_HIGH || hi_last);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cyc        <= '0;
            oe_q       <= 1'b0;
            data_out_q <= 8'h00;
            resp_valid <= 1'b0;
            resp_rdata <= 8'h00;
        end else begin
            cyc  <= cyc_nxt;
            oe_q <= oe_nxt;
            // Only a new write reloads the data so a trailing hold keeps it.
            if (accept && req_write)
                data_out_q <= req_wdata;
            resp_valid <= hi_last && cyc.host;
            if (hi_last && cyc.host)
                resp_rdata <= cyc.write ? 8'h00 : cpu_data_in;
        end
    end

    assign m2           = (phase == PH_HIGH);
    assign romsel       = ~(in_rom(cyc.addr) & m2);
    assign cpu_rw       = ~cyc.write;
    assign cpu_addr     = cyc.addr[14:0];
    assign cpu_data_out = data_out_q;
    assign cpu_data_oe  = oe_q;

    nes_bus_sync2 #(.RESET_VAL(1'b1)) u_irq_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (irq),
        .q     (irq_sync)
    );

endmodule

// File: tb/tb_nes_cpu_bus_master.sv
// Directed bench for nes_cpu_bus_master: idle cycling, host read/write,
// back-to-back reads, mid-cycle reset and IRQ synchronization.
module tb_nes_cpu_bus_master;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [15:0] req_addr = 16'h0000;
    logic [7:0]  req_wdata = 8'h00;
    logic        resp_valid;
    logic [7:0]  resp_rdata;
    logic        m2, romsel, cpu_rw, cpu_data_oe, irq_sync;
    logic [14:0] cpu_addr;
    logic [7:0]  cpu_data_out;
    logic [7:0]  cpu_data_in = 8'h00;
    logic        irq = 1'b1;

    int checks = 0;
    int errors = 0;

    nes_cpu_bus_master dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_write    (req_write),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .resp_valid   (resp_valid),
        .resp_rdata   (resp_rdata),
        .m2           (m2),
        .romsel       (romsel),
        .cpu_rw       (cpu_rw),
        .cpu_addr     (cpu_addr),
        .cpu_data_out (cpu_data_out),
        .cpu_data_oe  (cpu_data_oe),
        .cpu_data_in  (cpu_data_in),
        .irq          (irq),
        .irq_sync     (irq_sync)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // {m2, romsel, cpu_rw, req_ready, resp_valid, cpu_data_oe}
    function automatic logic [5:0] st();
        return {m2, romsel, cpu_rw, req_ready, resp_valid, cpu_data_oe};
    endfunction

    task automatic wait_ready();
        int n = 0;
        while (!req_ready && n < 30) begin
            step();
            n++;
        end
        chk("ready_wait", {31'd0, req_ready}, 32'd1);
    endtask

    // Returns at the first LOW clk of the accepted host cycle.
    task automatic issue(input logic w, input logic [15:0] a, input logic [7:0] d);
        req_valid = 1'b1;
        req_write = w;
        req_addr  = a;
        req_wdata = d;
        wait_ready();
        step();
        req_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic m;
        int   n;

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        chk("rst_st", {26'd0, st()}, {26'd0, 6'b011000});
        chk("rst_addr", {17'd0, cpu_addr}, 32'h0);
        chk("rst_dout", {24'd0, cpu_data_out}, 32'h0);
        chk("rst_rdata", {24'd0, resp_rdata}, 32'h0);
        chk("rst_irq", {31'd0, irq_sync}, 32'd1);
        rst_n = 1'b1;

        // Idle cycling: 5 low / 7 high, ready on last high clk only
        for (int i = 0; i < 24; i++) begin
            step();
            m = ((i % 12) >= 5);
            chk($sformatf("idle_st[%0d]", i), {26'd0, st()},
                {26'd0, m, 1'b1, 1'b1, ((i % 12) == 11), 1'b0, 1'b0});
            chk($sformatf("idle_addr[%0d]", i), {17'd0, cpu_addr}, 32'h0);
        end

        // Host read of ROM space
        cpu_data_in = 8'hA5;
        issue(1'b0, 16'h8000, 8'h00);
        for (int j = 0; j < 13; j++) begin
            if (j > 0) step();
            if (j < 12) begin
                m = (j >= 5);
                chk($sformatf("rd_st[%0d]", j), {26'd0, st()},
                    {26'd0, m, ~m, 1'b1, (j == 11), 1'b0, 1'b0});
                chk($sformatf("rd_addr[%0d]", j), {17'd0, cpu_addr}, 32'h0);
            end else begin
                chk("rd_resp_st", {26'd0, st()}, {26'd0, 6'b011010});
                chk("rd_rdata", {24'd0, resp_rdata}, 32'hA5);
            end
        end

        // Host write of SRAM space
        cpu_data_in = 8'h33;
        issue(1'b1, 16'h6000, 8'h5A);
        for (int j = 0; j < 14; j++) begin
            if (j > 0) step();
            if (j < 12) begin
                m = (j >= 5);
                chk($sformatf("wr_st[%0d]", j), {26'd0, st()},
                    {26'd0, m, 1'b1, 1'b0, (j == 11), 1'b0, m});
                chk($sformatf("wr_addr[%0d]", j), {17'd0, cpu_addr}, 32'h6000);
                chk($sformatf("wr_dout[%0d]", j), {24'd0, cpu_data_out}, 32'h5A);
            end else if (j == 12) begin
                chk("wr_hold_st", {26'd0, st()}, {26'd0, 6'b011011});
                chk("wr_rdata", {24'd0, resp_rdata}, 32'h0);
                chk("wr_hold_dout", {24'd0, cpu_data_out}, 32'h5A);
            end else begin
                chk("wr_post_st", {26'd0, st()}, {26'd0, 6'b011000});
            end
        end

        // Back-to-back reads, req_valid held
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr  = 16'hC000;
        wait_ready();
        for (int k = 0; k < 3; k++) begin
            step();
            if (k < 2) req_addr = 16'hC000 + 16'(k + 1);
            else       req_valid = 1'b0;
            chk($sformatf("b2b_addr[%0d]", k), {17'd0, cpu_addr}, 32'h4000 + k);
            chk($sformatf("b2b_resp[%0d]", k), {31'd0, resp_valid}, (k > 0) ? 32'd1 : 32'd0);
            if (k > 0)
                chk($sformatf("b2b_rdata[%0d]", k), {24'd0, resp_rdata}, 32'h10 + k - 1);
            cpu_data_in = 8'h10 + 8'(k);
            for (int j = 1; j < 12; j++) begin
                step();
                chk($sformatf("b2b_st[%0d.%0d]", k, j), {26'd0, st()},
                    {26'd0, (j >= 5), ~(j >= 5), 1'b1, (j == 11), 1'b0, 1'b0});
            end
        end
        step();
        chk("b2b_last_resp", {31'd0, resp_valid}, 32'd1);
        chk("b2b_last_rdata", {24'd0, resp_rdata}, 32'h12);
        chk("b2b_idle_addr", {17'd0, cpu_addr}, 32'h0);

        // Reset in the middle of HIGH of a ROM-space write
        issue(1'b1, 16'hE000, 8'h77);
        repeat (7) step();
        chk("mid_pre", {28'd0, m2, romsel, cpu_rw, cpu_data_oe}, {28'd0, 4'b1001});
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst", {28'd0, m2, romsel, cpu_rw, cpu_data_oe}, {28'd0, 4'b0110});
        chk("mid_rst_addr", {17'd0, cpu_addr}, 32'h0);
        chk("mid_rst_ready", {31'd0, req_ready}, 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 14; i++) begin
            step();
            chk($sformatf("post_rst[%0d]", i), {29'd0, cpu_rw, resp_valid, cpu_data_oe}, {29'd0, 3'b100});
            chk($sformatf("post_rst_m2[%0d]", i), {31'd0, m2}, {31'd0, ((i % 12) >= 5)});
            chk($sformatf("post_rst_addr[%0d]", i), {17'd0, cpu_addr}, 32'h0);
        end

        // IRQ synchronizer latency
        #3 irq = 1'b0;
        n = 0;
        while (n < 6) begin
            step();
            n++;
            if (!irq_sync) break;
        end
        chk("irq_fall_lat", {31'd0, (n >= 2 && n <= 3)}, 32'd1);
        #3 irq = 1'b1;
        n = 0;
        while (n < 6) begin
            step();
            n++;
            if (irq_sync) break;
        end
        chk("irq_rise_lat", {31'd0, (n >= 2 && n <= 3)}, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
